capture_stream_arbiter: RTL and testbench

Packet-granular 2:1 AXI4-Stream arbiter that merges the original stream (port 0) and the duplicated capture stream (port 1) from the packet duplicator onto one downstream port. Examples of downstream consumers are the DMA or an output queue. Once a packet is granted it is never interleaved with the other input. The output is decoupled by a 2-entry skid buffer so that the input-side ready is driven from a register.

---
 rtl/capture_stream_arbiter.sv | 123 ++++++++++++
 tb/tb_capture_stream_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_stream_arbiter.sv
// capture_stream_arbiter: packet-granular round-robin 2:1 AXI4-Stream merge with a 2-entry output skid buffer.
// Optional per-input packet counters are compiled in with `define CAPTURE_ARB_STATS_EN.
module capture_stream_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                              s_axis_tlast_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                              s_axis_tlast_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready
`ifdef CAPTURE_ARB_STATS_EN
    ,
    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1
`endif
);
    localparam int E = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH/8 + C_M_AXIS_TUSER_WIDTH + 1;

    if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH || C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH) begin : g_width_check
        $error("capture_stream_arbiter: input and output stream widths must match");
    end

    typedef enum logic {IDLE, PKT} state_t;

    state_t         state;
    logic           g;
    logic           last_grant;
    logic           sel;
    logic [1:0]     buf_count;
    logic           rd_ptr;
    logic           wr_ptr;
    logic [E-1:0]   mem [2];
    logic [E-1:0]   in_beat;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic           push;
    logic           pop;

    // Round-robin pick for the next packet, and muxing of the granted input into the buffer
    always_comb begin
        sel      = (s_axis_tvalid_0 & s_axis_tvalid_1) ? ~last_grant : s_axis_tvalid_1;
        in_valid = g ? s_axis_tvalid_1 : s_axis_tvalid_0;
        in_beat  = g ? {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1}
                     : {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
        in_last  = in_beat[E-1];
        in_ready = (state == PKT) && (buf_count != 2'd2);
        push     = in_valid & in_ready;
        pop      = m_axis_tvalid & m_axis_tready;
    end

    assign s_axis_tready_0 = in_ready & ~g;
    assign s_axis_tready_1 = in_ready & g;
    assign m_axis_tvalid   = (buf_count != 2'd0);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = mem[rd_ptr];

    // Grant FSM: one bubble cycle in IDLE per packet, grant locked until the tlast beat is accepted
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE) begin
            if (s_axis_tvalid_0 | s_axis_tvalid_1) begin
                g     <= sel;
                state <= PKT;
            end
        end else if (push & in_last) begin
            last_grant <= g;
            state      <= IDLE;
        end
    end

    // Skid buffer occupancy and pointers; reset discards any buffered beats
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            buf_count <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
        end else begin
            buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
            rd_ptr    <= rd_ptr ^ pop;
            wr_ptr    <= wr_ptr ^ push;
        end
    end

    // Skid buffer storage; contents are only observed while counted as valid
    always_ff @(posedge axi_aclk) begin
        if (push)
            mem[wr_ptr] <= in_beat;
    end

`ifdef CAPTURE_ARB_STATS_EN
    // Per-input packet counters, bumped on each accepted tlast beat, wrapping at 2^32
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            pkt_cnt_0 <= 32'd0;
            pkt_cnt_1 <= 32'd0;
        end else if (push & in_last) begin
            pkt_cnt_0 <= pkt_cnt_0 + {31'd0, ~g};
            pkt_cnt_1 <= pkt_cnt_1 + {31'd0, g};
        end
    end
`endif
endmodule

// File: tb/tb_capture_stream_arbiter.sv
// tb_capture_stream_arbiter: directed scoreboard bench for capture_stream_arbiter.
module tb_capture_stream_arbiter;
    typedef struct packed {
        logic [255:0] d;
        logic         l;
    } beat_t;

    logic         axi_aclk = 0;
    logic         reset = 1;
    logic [255:0] s_axis_tdata_0, s_axis_tdata_1, m_axis_tdata;
    logic [31:0]  s_axis_tstrb_0, s_axis_tstrb_1, m_axis_tstrb;
    logic [127:0] s_axis_tuser_0, s_axis_tuser_1, m_axis_tuser;
    logic         s_axis_tlast_0, s_axis_tlast_1, m_axis_tlast;
    logic         s_axis_tvalid_0, s_axis_tvalid_1, m_axis_tvalid;
    logic         s_axis_tready_0, s_axis_tready_1;
    logic         m_axis_tready = 1;
`ifdef CAPTURE_ARB_STATS_EN
    logic [31:0]  pkt_cnt_0, pkt_cnt_1;
`endif

    beat_t q0[$], q1[$], exp_q[$];
    int    out_cyc[$];
    int    cyc = 0, rise0 = 0, acc0 = 0, acc1 = 0;
    int    total = 0, bad = 0;

    capture_stream_arbiter dut (
        .axi_aclk(axi_aclk), .reset(reset),
        .s_axis_tdata_0(s_axis_tdata_0), .s_axis_tstrb_0(s_axis_tstrb_0), .s_axis_tuser_0(s_axis_tuser_0),
        .s_axis_tlast_0(s_axis_tlast_0), .s_axis_tvalid_0(s_axis_tvalid_0), .s_axis_tready_0(s_axis_tready_0),
        .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tstrb_1(s_axis_tstrb_1), .s_axis_tuser_1(s_axis_tuser_1),
        .s_axis_tlast_1(s_axis_tlast_1), .s_axis_tvalid_1(s_axis_tvalid_1), .s_axis_tready_1(s_axis_tready_1),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
`ifdef CAPTURE_ARB_STATS_EN
        , .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
`endif
    );

    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    function automatic logic [31:0] strb_of(input logic [255:0] d);
        return d[31:0] ^ 32'h5a5a_5a5a;
    endfunction

    function automatic logic [127:0] user_of(input logic [255:0] d);
        return {d[63:0], ~d[63:0]};
    endfunction

    function automatic beat_t bt(input logic [255:0] d, input logic l);
        return '{d: d, l: l};
    endfunction

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", n, act, req);
        end
    endtask

    task automatic drain(input string n);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && k < 300) begin
            @(negedge axi_aclk);
            k++;
        end
        chk({n, "_drain_timeout"}, k >= 300, 0);
        repeat (3) @(negedge axi_aclk);
    endtask

    task automatic ready_chk(input string n, input logic r0, input logic r1);
        chk({n, "_tready0"}, s_axis_tready_0, r0);
        chk({n, "_tready1"}, s_axis_tready_1, r1);
    endtask

    // input 0 source: handshake sampled mid-cycle, next beat presented just after the edge
    initial begin : drv0
        logic f;
        s_axis_tvalid_0 = 0; s_axis_tdata_0 = '0; s_axis_tstrb_0 = '0; s_axis_tuser_0 = '0; s_axis_tlast_0 = 0;
        forever begin
            @(negedge axi_aclk);
            f = s_axis_tvalid_0 & s_axis_tready_0 & ~reset;
            @(posedge axi_aclk);
            #1;
            if (f) begin void'(q0.pop_front()); acc0++; end
            if (q0.size() != 0) begin
                if (!s_axis_tvalid_0) rise0 = cyc;
                s_axis_tvalid_0 = 1;
                s_axis_tdata_0 = q0[0].d; s_axis_tstrb_0 = strb_of(q0[0].d);
                s_axis_tuser_0 = user_of(q0[0].d); s_axis_tlast_0 = q0[0].l;
            end else s_axis_tvalid_0 = 0;
        end
    end

    // input 1 source
    initial begin : drv1
        logic f;
        s_axis_tvalid_1 = 0; s_axis_tdata_1 = '0; s_axis_tstrb_1 = '0; s_axis_tuser_1 = '0; s_axis_tlast_1 = 0;
        forever begin
            @(negedge axi_aclk);
            f = s_axis_tvalid_1 & s_axis_tready_1 & ~reset;
            @(posedge axi_aclk);
            #1;
            if (f) begin void'(q1.pop_front()); acc1++; end
            if (q1.size() != 0) begin
                s_axis_tvalid_1 = 1;
                s_axis_tdata_1 = q1[0].d; s_axis_tstrb_1 = strb_of(q1[0].d);
                s_axis_tuser_1 = user_of(q1[0].d); s_axis_tlast_1 = q1[0].l;
            end else s_axis_tvalid_1 = 0;
        end
    end

    // output monitor: every output handshake is checked against the head of the scoreboard
    initial begin : mon
        beat_t e;
        forever begin
            @(negedge axi_aclk);
            if (!reset && m_axis_tvalid && m_axis_tready) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat act=%0h req=none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata},
                        {e.l, user_of(e.d), strb_of(e.d), e.d});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        // reset release with both inputs valid throughout reset
        q0.push_back(bt(256'hA0, 1)); q1.push_back(bt(256'hB0, 1));
        exp_q.push_back(bt(256'hA0, 1)); exp_q.push_back(bt(256'hB0, 1));
        for (int i = 0; i < 4; i++) begin
            @(posedge axi_aclk);
            @(negedge axi_aclk);
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            ready_chk("rst", 0, 0);
        end
        @(posedge axi_aclk); #1 reset = 0;
        @(negedge axi_aclk); ready_chk("rel_idle", 0, 0);
        @(negedge axi_aclk); ready_chk("rel_grant0", 1, 0);
        drain("reset");

        // contention: two-beat packets on both inputs alternate A,B,A,B
        out_cyc.delete();
        q0.push_back(bt(256'hA1, 0)); q0.push_back(bt(256'hA2, 1));
        q0.push_back(bt(256'hA3, 0)); q0.push_back(bt(256'hA4, 1));
        q1.push_back(bt(256'hB1, 0)); q1.push_back(bt(256'hB2, 1));
        q1.push_back(bt(256'hB3, 0)); q1.push_back(bt(256'hB4, 1));
        exp_q.push_back(bt(256'hA1, 0)); exp_q.push_back(bt(256'hA2, 1));
        exp_q.push_back(bt(256'hB1, 0)); exp_q.push_back(bt(256'hB2, 1));
        exp_q.push_back(bt(256'hA3, 0)); exp_q.push_back(bt(256'hA4, 1));
        exp_q.push_back(bt(256'hB3, 0)); exp_q.push_back(bt(256'hB4, 1));
        drain("contention");
        chk("cont_beats", out_cyc.size(), 8);
        for (int i = 1; i < out_cyc.size(); i++)
            chk("cont_gap", out_cyc[i] - out_cyc[i-1], (i % 2) ? 1 : 2);

        // single three-beat packet: first output two cycles after tvalid, then back to back
        out_cyc.delete();
        q0.push_back(bt(256'h1, 0)); q0.push_back(bt(256'h2, 0)); q0.push_back(bt(256'h3, 1));
        exp_q.push_back(bt(256'h1, 0)); exp_q.push_back(bt(256'h2, 0)); exp_q.push_back(bt(256'h3, 1));
        drain("single");
        chk("single_beats", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            chk("single_latency", out_cyc[0] - rise0, 2);
            chk("single_gap1", out_cyc[1] - out_cyc[0], 1);
            chk("single_gap2", out_cyc[2] - out_cyc[1], 1);
        end

        // backpressure: only two beats enter the skid buffer while the output is stalled
        m_axis_tready = 0;
        acc0 = 0;
        for (int i = 1; i <= 5; i++) begin
            q0.push_back(bt(256'hE0 + 256'(i), i == 5));
            exp_q.push_back(bt(256'hE0 + 256'(i), i == 5));
        end
        repeat (8) @(negedge axi_aclk);
        chk("bp_accepted", acc0, 2);
        ready_chk("bp_full", 0, 0);
        chk("bp_m_tvalid", m_axis_tvalid, 1);
        @(posedge axi_aclk); #1;
        m_axis_tready = 1;
        out_cyc.delete();
        @(negedge axi_aclk); ready_chk("bp_first_pop", 0, 0);
        @(negedge axi_aclk); ready_chk("bp_reopen", 1, 0);
        drain("backpressure");
        chk("bp_beats", out_cyc.size(), 5);
        for (int i = 1; i < out_cyc.size(); i++)
            chk("bp_gap", out_cyc[i] - out_cyc[i-1], 1);

        // reset after beat 2 of a four-beat packet on input 1; its remainder is a new packet
        m_axis_tready = 0;
        acc1 = 0;
        q1.push_back(bt(256'hC1, 0)); q1.push_back(bt(256'hC2, 0));
        q1.push_back(bt(256'hC3, 0)); q1.push_back(bt(256'hC4, 1));
        for (int k = 0; k < 30 && acc1 < 2; k++) @(negedge axi_aclk);
        chk("mid_accepted", acc1, 2);
        q0.push_back(bt(256'hD1, 1));
        exp_q.push_back(bt(256'hD1, 1)); exp_q.push_back(bt(256'hC3, 0)); exp_q.push_back(bt(256'hC4, 1));
        @(posedge axi_aclk); #1 reset = 1;
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("mid_flush_m_tvalid", m_axis_tvalid, 0);
        ready_chk("mid_rst", 0, 0);
`ifdef CAPTURE_ARB_STATS_EN
        chk("mid_cnt0", pkt_cnt_0, 0);
        chk("mid_cnt1", pkt_cnt_1, 0);
`endif
        @(posedge axi_aclk); #1;
        reset = 0;
        m_axis_tready = 1;
        @(negedge axi_aclk); ready_chk("mid_idle", 0, 0);
        @(negedge axi_aclk); ready_chk("mid_grant0", 1, 0);
        drain("reset_mid");

`ifdef CAPTURE_ARB_STATS_EN
        // two more packets on input 0, one more on input 1
        q0.push_back(bt(256'hF1, 1)); q0.push_back(bt(256'hF2, 1));
        q1.push_back(bt(256'hF3, 0)); q1.push_back(bt(256'hF4, 1));
        exp_q.push_back(bt(256'hF1, 1)); exp_q.push_back(bt(256'hF3, 0));
        exp_q.push_back(bt(256'hF4, 1)); exp_q.push_back(bt(256'hF2, 1));
        drain("stats");
        chk("stats_cnt0", pkt_cnt_0, 3);
        chk("stats_cnt1", pkt_cnt_1, 2);
        force dut.pkt_cnt_0 = 32'hFFFF_FFFF;
        @(posedge axi_aclk); #1;
        release dut.pkt_cnt_0;
        q0.push_back(bt(256'h99, 1));
        exp_q.push_back(bt(256'h99, 1));
        drain("wrap");
        chk("wrap_cnt0", pkt_cnt_0, 0);
        chk("wrap_cnt1", pkt_cnt_1, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
